// File: rtl/game_controller_if.sv
// Datapath bus between the memory-game controller and its datapath.
// Carries the status flags the datapath reports and the command strobes
// the controller issues. The controller uses the master modport, the
// datapath the slave modport.
interface game_controller_if;
  // Datapath status
  logic end_fpga;
  logic end_user;
  logic end_time;
  logic win;
  logic match;

  // Controller commands
  logic r1;
  logic r2;
  logic e1;
  logic e2;
  logic e3;
  logic e4;
  logic sel;

  modport master (
    input  end_fpga, end_user, end_time, win, match,
    output r1, r2, e1, e2, e3, e4, sel
  );

  modport slave (
    output end_fpga, end_user, end_time, win, match,
    input  r1, r2, e1, e2, e3, e4, sel
  );
endinterface

// File: rtl/game_controller.sv
// Memory-game control unit.
// Synchronises and edge-detects the active-low "enter" key, then sequences
// the setup, show, play, check, next-round and result phases, driving the
// datapath command strobes as a Moore decode of the state register.
// Optional key debounce is enabled by defining CTRL_DEBOUNCE_EN; without it
// the key pulse comes straight from the falling-edge detector and
// DEB_CYCLES has no effect.
module game_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 1_000_000
) (
  input  logic                  clock_50,
  input  logic                  reset,
  input  logic                  enter_n,
  game_controller_if.master     bus,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    INIT       = 3'd0,
    SETUP      = 3'd1,
    SEQUENCE   = 3'd2,
    PLAY       = 3'd3,
    CHECK      = 3'd4,
    NEXT_ROUND = 3'd5,
    RESULT     = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   keySync;
  logic                   enterP_q;

  // Shift the raw key through the synchroniser; idle level is released (1)
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], enter_n};
    end
  end

  assign keySync = sync_q[SYNC_STAGES-1];

`ifdef CTRL_DEBOUNCE_EN
  localparam int DebW = $clog2(DEB_CYCLES + 1);

  logic [DebW-1:0] debCnt_q;
  logic            armed_q;

  // Count consecutive low samples; fire once per press and re-arm only
  // after the key has been seen released
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      debCnt_q <= '0;
      armed_q  <= 1'b1;
      enterP_q <= 1'b0;
    end else begin
      enterP_q <= 1'b0;
      if (keySync) begin
        debCnt_q <= '0;
        armed_q  <= 1'b1;
      end else if (armed_q) begin
        if (debCnt_q == DebW'(DEB_CYCLES)) begin
          enterP_q <= 1'b1;
          armed_q  <= 1'b0;
          debCnt_q <= '0;
        end else begin
          debCnt_q <= debCnt_q + DebW'(1);
        end
      end
    end
  end
`else
  logic keyPrev_q;

  // Register a one-cycle pulse on each falling edge of the synchronised key
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      keyPrev_q <= 1'b1;
      enterP_q  <= 1'b0;
    end else begin
      keyPrev_q <= keySync;
      enterP_q  <= keyPrev_q & ~keySync;
    end
  end
`endif

  // State register
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the key pulse only matters in SETUP and RESULT, and a
  // timeout in PLAY takes priority over the player finishing
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:       state_d = SETUP;
      SETUP:      if (enterP_q) state_d = SEQUENCE;
      SEQUENCE:   if (bus.end_fpga) state_d = PLAY;
      PLAY: begin
        if (bus.end_time) begin
          state_d = RESULT;
        end else if (bus.end_user) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!bus.match || bus.win) begin
          state_d = RESULT;
        end else begin
          state_d = NEXT_ROUND;
        end
      end
      NEXT_ROUND: state_d = SEQUENCE;
      RESULT:     if (enterP_q) state_d = INIT;
      default:    state_d = INIT;
    endcase
  end

  // Moore decode of the datapath commands; anything not named is low
  always_comb begin
    bus.r1  = 1'b0;
    bus.r2  = 1'b0;
    bus.e1  = 1'b0;
    bus.e2  = 1'b0;
    bus.e3  = 1'b0;
    bus.e4  = 1'b0;
    bus.sel = 1'b0;
    case (state_q)
      INIT: begin
        bus.r1  = 1'b1;
        bus.r2  = 1'b1;
        bus.sel = 1'b1;
      end
      SETUP: begin
        bus.e1  = 1'b1;
        bus.r2  = 1'b1;
        bus.sel = 1'b1;
      end
      SEQUENCE: begin
        bus.e3  = 1'b1;
        bus.r2  = 1'b1;
        bus.sel = 1'b1;
      end
      PLAY: begin
        bus.e2  = 1'b1;
        bus.sel = 1'b1;
      end
      CHECK: begin
        bus.sel = 1'b1;
      end
      NEXT_ROUND: begin
        bus.e4  = 1'b1;
        bus.r2  = 1'b1;
        bus.sel = 1'b1;
      end
      default: begin
        bus.sel = 1'b0;
      end
    endcase
  end

  assign state = state_q;

endmodule
